// File: rtl/round_pace_scheduler.sv
`timescale 1ns/1ps
// Round sequencer for the light-memory game: owns level/difficulty, emits the pacing tick,
// launches rounds and decides pass/fail progression, game over and win.
// Ports: clk, reset (async active-low), start/start_difficulty from the debounced inputs,
// round_done/round_pass from the core; tick/round_start strobes, level/difficulty for
// the display, busy/game_over/game_won status flags.
module round_pace_scheduler #(
  parameter int PERIOD0         = 17500000,
  parameter int PERIOD1         = 15000000,
  parameter int PERIOD2         = 12500000,
  parameter int PERIOD3         = 10000000,
  parameter int CNT_W           = 25,
  parameter int LEVELS_PER_STEP = 2,
  parameter int MAX_LEVEL       = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] start_difficulty,
  input  logic       round_done,
  input  logic       round_pass,
  output logic       tick,
  output logic       round_start,
  output logic [7:0] level,
  output logic [1:0] difficulty,
  output logic       busy,
  output logic       game_over,
  output logic       game_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_RESULT,
    S_OVER,
    S_WON
  } state_t;

  localparam logic [CNT_W-1:0] RL0 = CNT_W'(PERIOD0 - 1);
  localparam logic [CNT_W-1:0] RL1 = CNT_W'(PERIOD1 - 1);
  localparam logic [CNT_W-1:0] RL2 = CNT_W'(PERIOD2 - 1);
  localparam logic [CNT_W-1:0] RL3 = CNT_W'(PERIOD3 - 1);
  localparam logic [7:0] PSTEP_LAST = 8'(LEVELS_PER_STEP - 1);
  localparam logic [7:0] LVL_MAX    = 8'(MAX_LEVEL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pcnt_q, pcnt_d;
  logic [7:0]       level_q, level_d;
  logic [1:0]       diff_q, diff_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] reload;

  // difficulty only changes outside RUN, so the period is stable for a round
  always_comb begin
    reload = RL0;
    unique case (diff_q)
      2'd0: reload = RL0;
      2'd1: reload = RL1;
      2'd2: reload = RL2;
      2'd3: reload = RL3;
      default: reload = RL0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      level_q <= 8'd1;
      diff_q  <= 2'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      level_q <= level_d;
      diff_q  <= diff_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    level_d = level_q;
    diff_d  = diff_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE, S_OVER, S_WON: begin
        if (start) begin
          diff_d  = start_difficulty;
          level_d = 8'd1;
          pcnt_d  = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        cnt_d   = reload;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          cnt_d = reload;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (round_done) begin
          pass_d  = round_pass;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (!pass_q) begin
          state_d = S_OVER;
        end else if (level_q == LVL_MAX) begin
          state_d = S_WON;
        end else begin
          level_d = level_q + 8'd1;
          if (pcnt_q == PSTEP_LAST) begin
            pcnt_d = '0;
            diff_d = (diff_q == 2'd3) ? 2'd3 : diff_q + 2'd1;
          end else begin
            pcnt_d = pcnt_q + 8'd1;
          end
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tick        = (state_q == S_RUN) && (cnt_q == '0);
  assign round_start = (state_q == S_ARM);
  assign busy        = (state_q == S_ARM) || (state_q == S_RUN)
                    || (state_q == S_RESULT);
  assign game_over   = (state_q == S_OVER);
  assign game_won    = (state_q == S_WON);
  assign level       = level_q;
  assign difficulty  = diff_q;

endmodule

// File: doc/round_pace_scheduler.md
# round_pace_scheduler

Sequencing controller for the light-memory game core. It owns difficulty and level, paces the core with a difficulty-dependent `tick` strobe, and launches rounds with a `round_start` / `round_done` handshake. It decides pass/fail progression, raises the difficulty every `LEVELS_PER_STEP` passed rounds, and ends the game on a failed round or on reaching `MAX_LEVEL`. It sits between the debounced button/switch inputs and the game core; `level` and `difficulty` also feed the seg7 driver.

## Interface
Parameters:
- `PERIOD0`, default 17500000: tick period in clk cycles at difficulty 0
- `PERIOD1`, default 15000000: tick period at difficulty 1
- `PERIOD2`, default 12500000: tick period at difficulty 2
- `PERIOD3`, default 10000000: tick period at difficulty 3
- `CNT_W`, default 25: tick counter width; every PERIODn must be ≥1 and ≤2^CNT_W
- `LEVELS_PER_STEP`, default 2: passed rounds per difficulty increment (≥1)
- `MAX_LEVEL`, default 99: level whose pass wins the game (1..255)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  debounced start request, sampled in IDLE/OVER/WON only
- `start_difficulty`  in  2  initial difficulty, captured on an accepted start
- `round_done`  in  1  one-cycle pulse from the core: round finished (honoured in RUN only)
- `round_pass`  in  1  round result, valid with `round_done`
- `tick`  out  1  one-cycle pacing strobe to the core
- `round_start`  out  1  one-cycle pulse: core begins a new round
- `level`  out  8  current level, 1-based
- `difficulty`  out  2  current difficulty 0..3
- `busy`  out  1  high in ARM/RUN/RESULT
- `game_over`  out  1  high in OVER
- `game_won`  out  1  high in WON

## Operation
- States: IDLE, ARM, RUN, RESULT, OVER, WON. Internal registers: tick counter `cnt` (CNT_W bits), pass counter `pcnt`, latched result `pass_q`.
- Reset (`reset`=0, asynchronous): state=IDLE, `cnt`=0, `pcnt`=0, `level`=1, `difficulty`=0. All strobes and flags are 0. Reset applied mid-round aborts the round immediately, with no `round_start` or `tick` emitted.
- IDLE: if `start`=1, load `difficulty`←`start_difficulty`, `level`←1, `pcnt`←0, then go to ARM.
- ARM (exactly 1 cycle): `round_start`=1; `cnt`←PERIOD(difficulty)−1; go to RUN.
- RUN: if `cnt`=0, `tick`=1 and `cnt`←PERIOD(difficulty)−1; otherwise `cnt`←`cnt`−1. If `round_done`=1, latch `pass_q`←`round_pass` and go to RESULT. When `round_done` coincides with `cnt`=0, the tick is still emitted. `start` is ignored.
- RESULT (exactly 1 cycle, no tick):
  - Fail: go to OVER; `level` and `difficulty` hold.
  - Pass and `level`=MAX_LEVEL: go to WON; `level` holds.
  - Pass otherwise: `level`←`level`+1. If `pcnt`=LEVELS_PER_STEP−1, then `pcnt`←0 and `difficulty`←min(`difficulty`+1, 3); otherwise `pcnt`+1. Go to ARM.
- OVER / WON: flags held high; `level`/`difficulty` frozen for display. `start`=1 behaves as in IDLE (reload, then go to ARM).
- `round_done` outside RUN is ignored. Difficulty changes take effect only at the next ARM reload; the period never changes mid-round.
- Outputs are Moore decodes of registered state/`cnt`; no combinational path from inputs to outputs.

## Timing
- `round_start` is in cycle t (ARM). The first `tick` is in cycle t+P, then every P cycles, where P=PERIOD(difficulty). With P=1, `tick` is high every RUN cycle.
- `round_done` at cycle u (RUN): RESULT at u+1. The next `round_start` (pass) is at u+2, or `game_over`/`game_won` rises at u+2.
- Accepted `start` at cycle s: `round_start` at s+1.
- `busy` falls in the same cycle `game_over`/`game_won` rises.

## Test plan
- **Reset/idle:** PERIODn=4,3,2,1, LEVELS_PER_STEP=2, MAX_LEVEL=5. Release reset and hold `start`=0 for 20 cycles → all strobes 0, `level`=1, `difficulty`=0, state IDLE.
- **Pacing:** `start` with `start_difficulty`=0, no `round_done` → `round_start` at s+1; `tick` at s+5, s+9, s+13; `busy`=1.
- **Progression:** pass 4 rounds from difficulty 0 → `level` 2,3,4,5; `difficulty` 0→1 after pass 2 and 1→2 after pass 4; each new round's tick spacing matches the new period (3, then 2).
- **Saturation/P=1:** start at `start_difficulty`=3 and pass 2 rounds → `difficulty` stays 3; `tick` high every RUN cycle.
- **Fail and coincidence:** `round_done`=1, `round_pass`=0 in the same cycle `cnt`=0 → `tick` emitted that cycle; `game_over`=1 two cycles later with `level`/`difficulty` frozen; a later `start` gives `round_start` next cycle and `level`=1.
- **Win/async reset:** pass at `level`=5 → `game_won`=1, `level`=5. In a separate run, assert `reset` mid-RUN between clock edges → outputs clear immediately; no `tick` after release until a new `start`.
